// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store controller.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

    // RV32 funct3 encodings for the load/store size field
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        RESP = 2'd3
    } state_t;

    // Access size in bytes from funct3[1:0]; 2'b11 never reaches a legal load.
    function automatic logic [2:0] size_bytes(input logic [1:0] f3_lo);
        case (f3_lo)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Stores only look at funct3[2]; loads must be one of the five encodings.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we)
            return f3[2];
        return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request / response / RAM-side bundle for the load/store controller.
// Latency: n/a (wires only).
// Backpressure: request valid/ready, response valid/ready, RAM side has none.
interface lsu_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        mem_en;
    logic [3:0]  mem_wr;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata0;
    logic [7:0]  mem_wdata1;
    logic [7:0]  mem_wdata2;
    logic [7:0]  mem_wdata3;
    logic [31:0] mem_rdata;

    // slave: the controller; master: the execute stage plus RAM model
    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_wr, mem_addr, mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3
    );
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_en, mem_wr, mem_addr, mem_wdata0, mem_wdata1, mem_wdata2, mem_wdata3
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Byte-lane alignment: byte enables over two words, shifted store data, split flag.
// Latency: combinational.
// Backpressure: none.
// Ports: i_off byte offset, i_n size in bytes, i_wdata right-justified store data;
//        o_be0/o_be1 lane enables for the first/second word, o_wsh shifted data, o_split.
module lsu_lane_align (
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_n,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be0,
    output logic [3:0]  o_be1,
    output logic [63:0] o_wsh,
    output logic        o_split
);
    logic [7:0] w_mask;
    logic [7:0] w_be;

    assign w_mask  = (8'd1 << i_n) - 8'd1;
    assign w_be    = w_mask << i_off;
    assign o_be0   = w_be[3:0];
    assign o_be1   = w_be[7:4];
    assign o_split = |w_be[7:4];
    assign o_wsh   = {32'd0, i_wdata} << {i_off, 3'b000};
endmodule

// File: rtl/lsu_mem_ctrl.sv
// RV32 load/store controller: word-aligned RAM accesses, misaligned split in two cycles.
// Latency: response 2 cycles after accept (3 when split, 1 for illegal funct3).
// Backpressure: one request outstanding; response held in RESP until rsp_ready.
// Ports: clk, rst (sync, active-high); bus = request, response and RAM-side signals.
import lsu_pkg::*;

module lsu_mem_ctrl #(
    parameter int AWIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    lsu_mem_ctrl_if.slave bus
);
    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rd_lo;
    logic [31:0] r_rdata;
    logic [2:0]  r_n;
    logic        r_we;
    logic        r_zext;
    logic        r_err;

    logic        w_accept;
    logic        w_illegal;
    logic        w_acc0;
    logic        w_acc1;
    logic        w_split;
    logic        w_load_done;
    logic [3:0]  w_be0;
    logic [3:0]  w_be1;
    logic [63:0] w_wsh;
    logic [31:0] w_word;
    logic [31:0] w_lanes;
    logic [63:0] w_merged;
    logic [31:0] w_raw;
    logic [31:0] w_ext;

    assign w_accept  = bus.req_valid && bus.req_ready;
    assign w_illegal = f3_illegal(bus.req_we, bus.req_funct3);

    lsu_lane_align u_align (
        .i_off   (r_addr[1:0]),
        .i_n     (r_n),
        .i_wdata (r_wdata),
        .o_be0   (w_be0),
        .o_be1   (w_be1),
        .o_wsh   (w_wsh),
        .o_split (w_split)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = w_illegal ? RESP : ACC0;
            ACC0: w_next = w_split ? ACC1 : RESP;
            ACC1: w_next = RESP;
            RESP: if (bus.rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (rst) w_next = IDLE;
    end

    // Gating with rst keeps a reset during ACC1 from committing the second word.
    assign w_acc0 = (r_state == ACC0) && !rst;
    assign w_acc1 = (r_state == ACC1) && !rst;
    assign w_word = {r_addr[31:2], 2'b00};

    assign bus.req_ready = (r_state == IDLE) && !rst;
    assign bus.rsp_valid = (r_state == RESP) && !rst;
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;
    assign bus.mem_en    = w_acc0 || w_acc1;
    assign bus.mem_addr  = w_acc0 ? w_word : (w_acc1 ? w_word + 32'd4 : 32'd0);
    assign bus.mem_wr    = (w_acc0 && r_we) ? w_be0 : ((w_acc1 && r_we) ? w_be1 : 4'd0);
    assign w_lanes       = w_acc0 ? w_wsh[31:0] : (w_acc1 ? w_wsh[63:32] : 32'd0);
    assign bus.mem_wdata0 = w_lanes[7:0];
    assign bus.mem_wdata1 = w_lanes[15:8];
    assign bus.mem_wdata2 = w_lanes[23:16];
    assign bus.mem_wdata3 = w_lanes[31:24];

    // Result is formed in the last access cycle straight from mem_rdata, so
    // the high word never needs its own register.
    assign w_load_done = ((r_state == ACC0) && !w_split) || (r_state == ACC1);
    assign w_merged    = (r_state == ACC1) ? {bus.mem_rdata, r_rd_lo} : {32'd0, bus.mem_rdata};
    assign w_raw       = 32'(w_merged >> {r_addr[1:0], 3'b000});

    always_comb begin
        w_ext = w_raw;
        case (r_n)
            3'd1: w_ext = r_zext ? {24'd0, w_raw[7:0]}  : {{24{w_raw[7]}},  w_raw[7:0]};
            3'd2: w_ext = r_zext ? {16'd0, w_raw[15:0]} : {{16{w_raw[15]}}, w_raw[15:0]};
            default: w_ext = w_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_rd_lo <= 32'd0;
            r_rdata <= 32'd0;
            r_n     <= 3'd0;
            r_we    <= 1'b0;
            r_zext  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_we    <= bus.req_we;
                r_zext  <= bus.req_funct3[2];
                r_n     <= size_bytes(bus.req_funct3[1:0]);
                r_err   <= w_illegal;
                r_rdata <= 32'd0;
            end
            if (r_state == ACC0)
                r_rd_lo <= bus.mem_rdata;
            if (w_load_done)
                r_rdata <= r_we ? 32'd0 : w_ext;
        end
    end

    a_awidth: assert property (@(posedge clk) AWIDTH > 0 && AWIDTH <= 30);
    a_aligned: assert property (@(posedge clk) bus.mem_addr[1:0] == 2'b00);

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: byte-level reference memory, per-cycle output compare.
// Latency: n/a.
// Backpressure: response stalls driven explicitly by the directed sequence.
module tb_lsu_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ram_clr = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_ctrl_if bus();
    lsu_mem_ctrl #(.AWIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  wr;
        logic [31:0] lanes;
    } acc_t;

    acc_t        exp_q[$];
    logic        pending = 1'b0;
    logic [31:0] exp_rd  = 32'd0;
    logic        exp_err = 1'b0;
    logic [7:0]  mm [logic [31:0]];

    // RAM device: combinational read, lane-strobed write on the rising edge
    logic [31:0] ram [256];
    logic [31:0] lanes_w;
    assign lanes_w = {bus.mem_wdata3, bus.mem_wdata2, bus.mem_wdata1, bus.mem_wdata0};
    assign bus.mem_rdata = ram[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
        end else if (bus.mem_en) begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_wr[i]) ram[bus.mem_addr[9:2]][8*i +: 8] <= lanes_w[8*i +: 8];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rdbyte(input logic [31:0] a);
        return mm.exists(a) ? mm[a] : 8'd0;
    endfunction

    // Per-cycle compare against the expected access queue and pending response
    initial begin
        acc_t a;
        logic [31:0] m;
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
                chk("rst_mem_en",    {31'd0, bus.mem_en}, 32'd0);
                chk("rst_mem_wr",    {28'd0, bus.mem_wr}, 32'd0);
                chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
            end else if (exp_q.size() > 0) begin
                a = exp_q.pop_front();
                m = {{8{a.wr[3]}}, {8{a.wr[2]}}, {8{a.wr[1]}}, {8{a.wr[0]}}};
                chk("acc_mem_en",   {31'd0, bus.mem_en}, 32'd1);
                chk("acc_mem_addr", bus.mem_addr, a.addr);
                chk("acc_mem_wr",   {28'd0, bus.mem_wr}, {28'd0, a.wr});
                chk("acc_lanes",    lanes_w & m, a.lanes & m);
                chk("acc_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
                chk("acc_req_ready", {31'd0, bus.req_ready}, 32'd0);
            end else begin
                chk("idle_mem_en",   {31'd0, bus.mem_en}, 32'd0);
                chk("idle_mem_wr",   {28'd0, bus.mem_wr}, 32'd0);
                chk("idle_mem_addr", bus.mem_addr, 32'd0);
                chk("rsp_valid",     {31'd0, bus.rsp_valid}, {31'd0, pending});
                chk("req_ready",     {31'd0, bus.req_ready}, {31'd0, !pending});
                if (pending) begin
                    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
                    chk("rsp_err",   {31'd0, bus.rsp_err}, {31'd0, exp_err});
                end
            end
        end
    end

    // Wait for ready, present the request for one edge, then build expectations
    task automatic accept_req(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata);
        int k = 0;
        int n;
        int ln;
        logic ill;
        logic hi;
        logic [31:0] a;
        logic [31:0] w0;
        logic [31:0] val;
        acc_t r0;
        acc_t r1;
        @(negedge clk);
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_wait", {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        ill = we ? f3[2] : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        n   = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
        if (ill) begin
            exp_rd  = 32'd0;
            exp_err = 1'b1;
        end else begin
            w0  = {addr[31:2], 2'b00};
            r0  = '{w0, 4'd0, 32'd0};
            r1  = '{w0 + 32'd4, 4'd0, 32'd0};
            hi  = 1'b0;
            val = 32'd0;
            for (int i = 0; i < n; i++) begin
                a  = addr + i;
                ln = int'(a[1:0]);
                if ({a[31:2], 2'b00} != w0) hi = 1'b1;
                if (we) begin
                    mm[a] = wdata[8*i +: 8];
                    if ({a[31:2], 2'b00} != w0) begin
                        r1.wr[ln] = 1'b1;
                        r1.lanes[8*ln +: 8] = wdata[8*i +: 8];
                    end else begin
                        r0.wr[ln] = 1'b1;
                        r0.lanes[8*ln +: 8] = wdata[8*i +: 8];
                    end
                end else begin
                    val = val | ({24'd0, rdbyte(a)} << (8*i));
                end
            end
            if (!f3[2] && n == 1) val = {{24{val[7]}}, val[7:0]};
            if (!f3[2] && n == 2) val = {{16{val[15]}}, val[15:0]};
            exp_rd  = we ? 32'd0 : val;
            exp_err = 1'b0;
            exp_q.push_back(r0);
            if (hi) exp_q.push_back(r1);
        end
        pending = 1'b1;
    endtask

    task automatic finish_rsp(input int hold, output logic [31:0] rd,
                              output logic err, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.rsp_valid && lat < 20);
        chk("rsp_wait", {31'd0, bus.rsp_valid}, 32'd1);
        repeat (hold) @(negedge clk);
        bus.rsp_ready = 1'b1;
        rd  = bus.rsp_rdata;
        err = bus.rsp_err;
        @(posedge clk);
        #1;
        pending = 1'b0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int hold,
                          output logic [31:0] rd, output logic err, output int lat);
        accept_req(we, f3, addr, wdata);
        finish_rsp(hold, rd, err, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        ram_clr = 1'b0;
        @(negedge clk);
        chk("reset_rdata", bus.rsp_rdata, 32'd0);
        chk("reset_err", {31'd0, bus.rsp_err}, 32'd0);

        do_req(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4, 0, rd, err, lat);
        chk("sw10_lat", lat, 32'd2);
        chk("sw10_rd", rd, 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, err, lat);
        chk("lw10_lit", rd, 32'hA1B2C3D4);
        chk("lw10_lat", lat, 32'd2);

        do_req(1'b1, 3'b000, 32'h13, 32'hFFFFFF80, 0, rd, err, lat);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, 0, rd, err, lat);
        chk("lb13_lit", rd, 32'hFFFFFF80);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, 1, rd, err, lat);
        chk("lbu13_lit", rd, 32'h00000080);

        do_req(1'b1, 3'b010, 32'h0E, 32'h11223344, 0, rd, err, lat);
        chk("sw0e_lat", lat, 32'd3);
        do_req(1'b0, 3'b010, 32'h0E, 32'h0, 0, rd, err, lat);
        chk("lw0e_lit", rd, 32'h11223344);
        chk("lw0e_lat", lat, 32'd3);
        do_req(1'b0, 3'b101, 32'h11, 32'h0, 0, rd, err, lat);
        chk("lhu11_lit", rd, 32'h0000B211);

        do_req(1'b1, 3'b001, 32'hFFFFFFFF, 32'h1234BEEF, 0, rd, err, lat);
        do_req(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 0, rd, err, lat);
        chk("lh_wrap_lit", rd, 32'hFFFFBEEF);
        do_req(1'b0, 3'b101, 32'hFFFFFFFF, 32'h0, 0, rd, err, lat);
        chk("lhu_wrap_lit", rd, 32'h0000BEEF);

        do_req(1'b0, 3'b011, 32'h10, 32'h0, 3, rd, err, lat);
        chk("ill_ld_err", {31'd0, err}, 32'd1);
        chk("ill_ld_rd", rd, 32'd0);
        chk("ill_ld_lat", lat, 32'd1);
        do_req(1'b1, 3'b100, 32'h10, 32'hDEADBEEF, 0, rd, err, lat);
        chk("ill_st_err", {31'd0, err}, 32'd1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, err, lat);
        chk("after_ill_lit", rd, 32'h80B21122);

        // reset lands in the ACC1 cycle of a split store
        accept_req(1'b1, 3'b010, 32'h22, 32'h55667788);
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        pending = 1'b0;
        mm.delete(32'h24);
        mm.delete(32'h25);
        @(posedge clk);
        #1;
        rst = 1'b0;
        do_req(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, err, lat);
        chk("rst_acc0_kept", rd, 32'h77880000);
        do_req(1'b0, 3'b010, 32'h24, 32'h0, 0, rd, err, lat);
        chk("rst_acc1_clean", rd, 32'h00000000);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
# lsu_mem_ctrl

Load/store controller sitting directly upstream of the byte-lane data RAM. It accepts one RV32 load/store request at a time from the execute stage and issues word-aligned RAM accesses with per-lane write strobes and lane data. Word-crossing (misaligned) accesses are split into two consecutive RAM cycles. Read data is merged, byte-extracted and sign- or zero-extended before being returned on a valid/ready response channel.

## Interface
- `AWIDTH`, 8: RAM word-address width. The block passes the full 32-bit address through; this parameter is used only for documentation and assertions.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE while `rst`=0.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32 funct3.
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `rsp_valid` out 1: response present; held until accepted.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and errors.
- `rsp_err` out 1: illegal funct3.
- `mem_en` out 1: RAM enable.
- `mem_wr` out 4: per-lane write strobes.
- `mem_addr` out 32: always word-aligned (`[1:0]`=00).
- `mem_wdata0`..`mem_wdata3` out 8 each: lane data.
- `mem_rdata` in 32: combinational RAM read data for the current `mem_addr`.

## Operation
- States: IDLE, ACC0, ACC1, RESP.
- IDLE → ACC0 on `req_valid && req_ready`.
  - The request is latched: addr, we, funct3, wdata.
  - Derived on capture: off = addr[1:0]; n = 1/2/4 bytes from funct3[1:0].
- IDLE → RESP directly for an illegal funct3.
  - Illegal: 011, 110, 111 for loads; any value with funct3[2]=1 for stores.
  - In this case `rsp_err`=1, `rsp_rdata`=0, and no RAM access occurs.
- Byte-enable span: be[7:0] = ((1<<n)-1) << off.
  - be0 = be[3:0]; be1 = be[7:4].
  - The access is split when be1 ≠ 0.
- Store data: wsh[63:0] = {32'b0, wdata} << (8·off).
  - ACC0 lanes come from wsh[31:0]; ACC1 lanes come from wsh[63:32].
- ACC0 cycle:
  - mem_en=1, mem_addr={addr[31:2],2'b00}, mem_wr = we ? be0 : 0.
  - rd_lo is captured from mem_rdata.
  - Next state: ACC1 if split, else RESP.
- ACC1 cycle:
  - mem_en=1, mem_addr = {addr[31:2],2'b00} + 4 (mod 2^32, so 0xFFFFFFFC wraps to 0), mem_wr = we ? be1 : 0.
  - rd_hi is captured. Next state: RESP.
- Load result: r = ({rd_hi, rd_lo} >> 8·off), truncated to n bytes.
  - Sign-extended when funct3[2]=0, zero-extended otherwise.
  - Registered into `rsp_rdata` on entry to RESP.
- RESP: `rsp_valid`=1. On `rsp_ready`, go to IDLE and clear `rsp_valid`.
- Outside ACC0/ACC1: mem_en=0, mem_wr=0, mem_addr=0, all lane data 0.
- `rst`=1 in any state:
  - Next state is IDLE.
  - Reset values: req_ready=0 during reset; rsp_valid=0, rsp_rdata=0, rsp_err=0; mem_en=0, mem_wr=0.
  - An ACC0 write already committed before reset stays in RAM; no rollback.

## Timing
- Aligned or within-word access: request accepted at edge t, ACC0 during t→t+1, rsp_valid from t+1+1 = cycle t+2.
- Split access: rsp_valid from cycle t+3.
- Error: rsp_valid from cycle t+1.
- RAM writes commit at the rising edge that ends ACC0/ACC1.
- Throughput: one request outstanding. req_ready stays low from acceptance until the cycle after the response handshake.
- Back-to-back requests: if a response is accepted at edge e, IDLE is at e and req_ready=1 during cycle e+1.
- All outputs are registered state decodes or registered data; there is no combinational path from req_* to mem_*.

## Structure
- `lsu_pkg` holds:
  - funct3 constants (F3_B/H/W/BU/HU);
  - the state enum {IDLE, ACC0, ACC1, RESP};
  - the size-decode function.
- One sub-module, `lsu_lane_align`, is purely combinational. Inputs: off, n, wdata. Outputs: be0, be1, wsh, split.
  - It is shared by the FSM and by the load extractor.
- The FSM, capture registers and extend/merge logic live in `lsu_mem_ctrl`.

## Test plan
- SW 0xA1B2C3D4 at 0x10, then LW 0x10:
  - mem_wr=1111 at mem_addr 0x10.
  - Load returns 0xA1B2C3D4 at t+2.
- SB 0x80 at 0x13, then LB 0x13 and LBU 0x13:
  - mem_wr=1000.
  - LB returns 0xFFFFFF80; LBU returns 0x00000080.
- SW 0x11223344 at 0x0E (split):
  - ACC0: addr 0x0C, mem_wr=1100.
  - ACC1: addr 0x10, mem_wr=0011.
  - LW 0x0E returns 0x11223344 at t+3.
- LH at 0xFFFFFFFF: ACC1 mem_addr wraps to 0x00000000; the halfword is merged correctly.
- funct3=011 load:
  - mem_en never asserts.
  - rsp_valid at t+1 with rsp_err=1, rsp_rdata=0.
  - Holding rsp_ready=0 for 3 cycles keeps the response stable.
- rst asserted during ACC1 of a split SW:
  - Next cycle: IDLE, mem_en=0, rsp_valid=0.
  - Lanes written in ACC0 remain; the ACC1 lanes are unchanged.
